gen_collector: RTL and testbench
================================

GEN_COLLECTOR -- requirements
Module: gen_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of generator output and of n.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries (power of two, >=2).
REQ-003 SHALL have these ports (name, direction, width, meaning):
  __clock       in   1      single clock; all logic on its rising edge
  __reset       in   1      synchronous, active-high reset
  __start       in   1      host request to begin a run
  n             in   WIDTH  host run argument
  __done        out  1      one-cycle pulse when a run has terminated
  gen_n         out  WIDTH  argument driven to generator
  gen_start     out  1      start strobe to generator
  gen_ready     out  1      ready to generator
  gen_valid     in   1      generator output valid
  gen_done      in   1      generator terminal beat marker
  gen_output_0  in   WIDTH  generator data
  rd_ready      in   1      host pops buffer head
  rd_valid      out  1      buffer non-empty
  rd_data       out  WIDTH  buffer head (first-word-fall-through)
  count         out  32     data beats accepted this run
  sum           out  WIDTH  running sum of accepted data (see Configuration)

Function
REQ-004 SHALL implement states IDLE, LAUNCH, COLLECT, FINISH.
REQ-005 IDLE: when __start=1 and the buffer is empty, SHALL latch n into gen_n, clear count and sum, and go to LAUNCH next cycle; __start SHALL be ignored while the buffer is non-empty or outside IDLE.
REQ-006 LAUNCH: SHALL hold gen_start=1 and gen_ready=1 for exactly one cycle, then go to COLLECT.
REQ-007 gen_start SHALL be 0 in every state except LAUNCH; gen_n SHALL stay stable from IDLE exit until the next accepted __start.
REQ-008 COLLECT: gen_ready SHALL be combinationally 1 iff the buffer is not full; a pop in the same cycle SHALL NOT raise gen_ready.
REQ-009 A data beat SHALL be accepted on gen_valid=1, gen_ready=1 and gen_done=0: push gen_output_0, increment count by 1 (32-bit wrap), update sum.
REQ-010 gen_done=1 in COLLECT SHALL be treated as terminal regardless of gen_valid or gen_ready: its gen_output_0 SHALL NOT be pushed or counted, and the block SHALL go to FINISH next cycle.
REQ-011 The generator's done marker lasts one cycle; the block SHALL therefore sample gen_done every COLLECT cycle, including while the buffer is full.
REQ-012 FINISH: SHALL pulse __done=1 for exactly one cycle with gen_ready=0, then go to IDLE; buffer contents, count and sum SHALL be retained.
REQ-013 Buffer SHALL be a DEPTH-entry circular FIFO with wrapping read/write pointers; rd_valid=1 iff non-empty; pop on rd_valid and rd_ready.
REQ-014 Simultaneous push and pop SHALL leave occupancy unchanged and remain correct when full or empty; pop while empty SHALL be ignored.
REQ-015 Host reads SHALL be permitted in every state, including during COLLECT.
REQ-016 gen_valid/gen_output_0 outside COLLECT SHALL be ignored.

Reset
REQ-017 __reset=1 SHALL, on the next rising edge, force state IDLE, empty the buffer, and clear __done, gen_start, gen_ready, rd_valid, count, sum, and gen_n to 0, from any state including mid-run.
REQ-018 Reset SHALL take priority over __start, the generator inputs and rd_ready in the same cycle.

Configuration
REQ-019 Macro GEN_COLLECTOR_SUM_EN defined: sum SHALL be the WIDTH-bit wrap-around sum of accepted data beats, cleared at run start and on reset.
REQ-020 Macro GEN_COLLECTOR_SUM_EN undefined: sum port SHALL remain present and tied to 0, and no adder SHALL be synthesized.

Verification
REQ-021 Bench SHALL cover these scenarios:
  - Producer model emits 1,1,3,5 then a done beat carrying 0, rd_ready=1 -> rd_data 1,1,3,5; count=4; sum=10 (macro on); one __done pulse; terminator not stored.
  - Immediate termination: first beat has gen_done=1 -> count=0, buffer empty, __done pulses, state returns to IDLE.
  - DEPTH=8, rd_ready=0, producer offers 10 items -> gen_ready=0 after 8 pushes, producer stalls; raising rd_ready delivers all 10 in order.
  - Buffer full with a one-cycle gen_done -> terminal detected, FINISH entered, the 8 stored items remain readable.
  - __reset asserted mid-COLLECT with 3 items buffered -> next cycle rd_valid=0, count=0, state IDLE; a subsequent __start runs normally.
  - __start while buffer non-empty -> ignored, gen_start stays 0; after the buffer is drained, __start launches with gen_start high for 1 cycle.

Source files
------------

// File: rtl/gen_collector.sv
// gen_collector: launches a generator run, buffers its data beats in a
// DEPTH-entry FWFT circular FIFO and reports beat count and (optionally) sum.
// Optional feature macro: GEN_COLLECTOR_SUM_EN enables the running sum adder;
// without it the sum port is tied to zero.
module gen_collector #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             __clock,
   input  logic             __reset,
   input  logic             __start,
   input  logic [WIDTH-1:0] n,
   output logic             __done,
   output logic [WIDTH-1:0] gen_n,
   output logic             gen_start,
   output logic             gen_ready,
   input  logic             gen_valid,
   input  logic             gen_done,
   input  logic [WIDTH-1:0] gen_output_0,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [31:0]      count,
   output logic [WIDTH-1:0] sum
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StLaunch  = 2'd1;
   localparam logic [1:0] StCollect = 2'd2;
   localparam logic [1:0] StFinish  = 2'd3;

   localparam logic [AW:0] PtrOne = 1;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] gen_n_q, gen_n_d;
   logic [31:0]      count_q, count_d;
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty, full, push, pop, run_start;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign run_start = (state_q == StIdle) && __start && empty;
   // gen_ready looks only at full, so a same-cycle pop never admits a push into a full buffer.
   assign gen_ready = (state_q == StLaunch) || ((state_q == StCollect) && !full);
   assign gen_start = (state_q == StLaunch);
   assign __done    = (state_q == StFinish);
   assign push      = (state_q == StCollect) && gen_valid && gen_ready && !gen_done;
   assign pop       = !empty && rd_ready;

   assign gen_n    = gen_n_q;
   assign count    = count_q;
   assign rd_valid = !empty;
   assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];

   // Next-state logic for the run FSM, the latched argument and the beat counter.
   always_comb begin
      state_d = state_q;
      gen_n_d = gen_n_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (run_start) begin
               state_d = StLaunch;
               gen_n_d = n;
               count_d = '0;
            end
         end
         StLaunch: state_d = StCollect;
         StCollect: begin
            // The done marker is a one-cycle event, so it is honoured even when full.
            if (gen_done) begin
               state_d = StFinish;
            end else if (push) begin
               count_d = count_q + 32'd1;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM, argument, counter and FIFO pointer registers.
   always_ff @(posedge __clock) begin
      if (__reset) begin
         state_q  <= StIdle;
         gen_n_q  <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         gen_n_q <= gen_n_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
      end
   end

   // FIFO storage; left unreset since the pointers define validity.
   always_ff @(posedge __clock) begin
      if (push && !__reset) begin
         mem_q[wr_ptr_q[AW-1:0]] <= gen_output_0;
      end
   end

`ifdef GEN_COLLECTOR_SUM_EN
   logic [WIDTH-1:0] sum_q, sum_d;

   // Running wrap-around sum, cleared when a run is launched.
   always_comb begin
      sum_d = sum_q;
      if (run_start) begin
         sum_d = '0;
      end else if (push) begin
         sum_d = sum_q + gen_output_0;
      end
   end

   // Sum register.
   always_ff @(posedge __clock) begin
      if (__reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;
`else
   assign sum = '0;
`endif

endmodule

// File: tb/tb_gen_collector.sv
// Directed self-checking bench for gen_collector (DEPTH=8, WIDTH=32).
module tb_gen_collector;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 8;

   logic             __clock = 1'b0;
   logic             __reset, __start, gen_valid, gen_done, rd_ready;
   logic [WIDTH-1:0] n, gen_output_0;
   logic             __done, gen_start, gen_ready, rd_valid;
   logic [WIDTH-1:0] gen_n, rd_data, sum;
   logic [31:0]      count;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   logic [WIDTH-1:0] got_q[$];
   logic [WIDTH-1:0] prod_q[$];

   gen_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .__clock(__clock), .__reset(__reset), .__start(__start), .n(n), .__done(__done),
      .gen_n(gen_n), .gen_start(gen_start), .gen_ready(gen_ready), .gen_valid(gen_valid),
      .gen_done(gen_done), .gen_output_0(gen_output_0), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .sum(sum)
   );

   always #5 __clock = ~__clock;

   // Record host pops and strobes seen in the current cycle, then advance one clock.
   task automatic tick();
      if (rd_valid === 1'b1 && rd_ready === 1'b1) got_q.push_back(rd_data);
      if (__done === 1'b1) done_cnt++;
      if (gen_start === 1'b1) start_cnt++;
      @(posedge __clock);
      #1;
   endtask

   task automatic apply_reset();
      __reset = 1'b1;
      tick();
      __reset = 1'b0;
      got_q.delete();
      done_cnt = 0;
      start_cnt = 0;
   endtask

   task automatic start_run(input logic [WIDTH-1:0] arg);
      __start = 1'b1;
      n = arg;
      tick();
      __start = 1'b0;
   endtask

   // Offer prod_q items one per cycle while respecting gen_ready.
   task automatic produce(input int budget);
      logic acc;
      int cyc;
      cyc = 0;
      while (prod_q.size() > 0 && cyc < budget) begin
         gen_valid = 1'b1;
         gen_output_0 = prod_q[0];
         acc = gen_ready;
         tick();
         if (acc) void'(prod_q.pop_front());
         cyc++;
      end
      gen_valid = 1'b0;
   endtask

   task automatic done_beat(input logic [WIDTH-1:0] val);
      gen_valid = 1'b1;
      gen_done = 1'b1;
      gen_output_0 = val;
      tick();
      gen_valid = 1'b0;
      gen_done = 1'b0;
   endtask

   task automatic drain(input int budget);
      rd_ready = 1'b1;
      for (int i = 0; i < budget && rd_valid; i++) tick();
   endtask

   task automatic test_reset();
      __start = 1'b1; n = 32'hDEAD; gen_valid = 1'b1; gen_done = 1'b0;
      gen_output_0 = 32'h55; rd_ready = 1'b1;
      apply_reset();
      __start = 1'b0; gen_valid = 1'b0; rd_ready = 1'b0;
      vectors++; if (__done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", __done); end
      vectors++; if (gen_start !== 1'b0) begin miscompares++; $display("FAIL reset_gen_start got=%b exp=0", gen_start); end
      vectors++; if (gen_ready !== 1'b0) begin miscompares++; $display("FAIL reset_gen_ready got=%b exp=0", gen_ready); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      vectors++; if (count !== 32'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
      vectors++; if (sum !== 32'd0) begin miscompares++; $display("FAIL reset_sum got=%0d exp=0", sum); end
      vectors++; if (gen_n !== 32'd0) begin miscompares++; $display("FAIL reset_gen_n got=%0d exp=0", gen_n); end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] exp_d [4];
      logic [WIDTH-1:0] exp_sum;
      exp_d = '{32'd1, 32'd1, 32'd3, 32'd5};
`ifdef GEN_COLLECTOR_SUM_EN
      exp_sum = 32'd10;
`else
      exp_sum = 32'd0;
`endif
      apply_reset();
      rd_ready = 1'b1;
      start_run(32'd7);
      vectors++; if (gen_start !== 1'b1) begin miscompares++; $display("FAIL basic_launch_start got=%b exp=1", gen_start); end
      vectors++; if (gen_ready !== 1'b1) begin miscompares++; $display("FAIL basic_launch_ready got=%b exp=1", gen_ready); end
      vectors++; if (gen_n !== 32'd7) begin miscompares++; $display("FAIL basic_gen_n got=%0d exp=7", gen_n); end
      tick();
      vectors++; if (gen_start !== 1'b0) begin miscompares++; $display("FAIL basic_collect_start got=%b exp=0", gen_start); end
      prod_q = '{32'd1, 32'd1, 32'd3, 32'd5};
      produce(20);
      vectors++; if (prod_q.size() != 0) begin miscompares++; $display("FAIL basic_produce_timeout left=%0d exp=0", prod_q.size()); end
      done_beat(32'd0);
      vectors++; if (__done !== 1'b1) begin miscompares++; $display("FAIL basic_finish_done got=%b exp=1", __done); end
      vectors++; if (gen_ready !== 1'b0) begin miscompares++; $display("FAIL basic_finish_ready got=%b exp=0", gen_ready); end
      tick();
      vectors++; if (__done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got=%b exp=0", __done); end
      tick(); tick();
      vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL basic_nitems got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         vectors++; if (got_q[i] !== exp_d[i]) begin miscompares++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_d[i]); end
      end
      vectors++; if (count !== 32'd4) begin miscompares++; $display("FAIL basic_count got=%0d exp=4", count); end
      vectors++; if (sum !== exp_sum) begin miscompares++; $display("FAIL basic_sum got=%0d exp=%0d", sum, exp_sum); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_terminator got=%b exp=0", rd_valid); end
      vectors++; if (gen_n !== 32'd7) begin miscompares++; $display("FAIL basic_gen_n_hold got=%0d exp=7", gen_n); end
   endtask

   task automatic test_immediate();
      apply_reset();
      rd_ready = 1'b1;
      start_run(32'd3);
      tick();
      done_beat(32'd99);
      vectors++; if (__done !== 1'b1) begin miscompares++; $display("FAIL imm_done got=%b exp=1", __done); end
      vectors++; if (count !== 32'd0) begin miscompares++; $display("FAIL imm_count got=%0d exp=0", count); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL imm_empty got=%b exp=0", rd_valid); end
      tick();
      start_run(32'd4);
      vectors++; if (gen_start !== 1'b1) begin miscompares++; $display("FAIL imm_back_to_idle got=%b exp=1", gen_start); end
      tick();
      done_beat(32'd0);
      tick();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] exp_sum;
`ifdef GEN_COLLECTOR_SUM_EN
      exp_sum = 32'd1045;
`else
      exp_sum = 32'd0;
`endif
      apply_reset();
      rd_ready = 1'b0;
      start_run(32'd10);
      tick();
      for (int i = 0; i < 10; i++) prod_q.push_back(WIDTH'(100 + i));
      produce(14);
      vectors++; if (prod_q.size() != 2) begin miscompares++; $display("FAIL bp_stall left=%0d exp=2", prod_q.size()); end
      vectors++; if (gen_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full got=%b exp=0", gen_ready); end
      vectors++; if (count !== 32'd8) begin miscompares++; $display("FAIL bp_count_full got=%0d exp=8", count); end
      rd_ready = 1'b1;
      produce(20);
      vectors++; if (prod_q.size() != 0) begin miscompares++; $display("FAIL bp_produce_timeout left=%0d exp=0", prod_q.size()); end
      done_beat(32'd0);
      tick();
      drain(20);
      vectors++; if (got_q.size() != 10) begin miscompares++; $display("FAIL bp_nitems got=%0d exp=10", got_q.size()); end
      for (int i = 0; i < 10 && i < got_q.size(); i++) begin
         vectors++; if (got_q[i] !== WIDTH'(100 + i)) begin miscompares++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_q[i], 100 + i); end
      end
      vectors++; if (count !== 32'd10) begin miscompares++; $display("FAIL bp_count got=%0d exp=10", count); end
      vectors++; if (sum !== exp_sum) begin miscompares++; $display("FAIL bp_sum got=%0d exp=%0d", sum, exp_sum); end
   endtask

   task automatic test_full_done();
      apply_reset();
      rd_ready = 1'b0;
      start_run(32'd8);
      tick();
      for (int i = 0; i < 8; i++) prod_q.push_back(WIDTH'(200 + i));
      produce(12);
      vectors++; if (gen_ready !== 1'b0) begin miscompares++; $display("FAIL fd_ready_full got=%b exp=0", gen_ready); end
      done_beat(32'd999);
      vectors++; if (__done !== 1'b1) begin miscompares++; $display("FAIL fd_finish got=%b exp=1", __done); end
      vectors++; if (count !== 32'd8) begin miscompares++; $display("FAIL fd_count got=%0d exp=8", count); end
      tick();
      drain(12);
      vectors++; if (got_q.size() != 8) begin miscompares++; $display("FAIL fd_nitems got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         vectors++; if (got_q[i] !== WIDTH'(200 + i)) begin miscompares++; $display("FAIL fd_data[%0d] got=%0d exp=%0d", i, got_q[i], 200 + i); end
      end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL fd_empty got=%b exp=0", rd_valid); end
   endtask

   task automatic test_mid_reset();
      logic [WIDTH-1:0] exp_sum;
`ifdef GEN_COLLECTOR_SUM_EN
      exp_sum = 32'd42;
`else
      exp_sum = 32'd0;
`endif
      apply_reset();
      rd_ready = 1'b0;
      start_run(32'd9);
      tick();
      prod_q = '{32'd11, 32'd12, 32'd13};
      produce(10);
      vectors++; if (count !== 32'd3) begin miscompares++; $display("FAIL mr_count_pre got=%0d exp=3", count); end
      // Reset competes with start, a data beat and a pop in the same cycle.
      __reset = 1'b1; __start = 1'b1; gen_valid = 1'b1; gen_output_0 = 32'd77; rd_ready = 1'b1;
      tick();
      __reset = 1'b0; __start = 1'b0; gen_valid = 1'b0; rd_ready = 1'b0;
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL mr_rd_valid got=%b exp=0", rd_valid); end
      vectors++; if (count !== 32'd0) begin miscompares++; $display("FAIL mr_count got=%0d exp=0", count); end
      vectors++; if (gen_n !== 32'd0) begin miscompares++; $display("FAIL mr_gen_n got=%0d exp=0", gen_n); end
      vectors++; if (gen_start !== 1'b0) begin miscompares++; $display("FAIL mr_gen_start got=%b exp=0", gen_start); end
      vectors++; if (gen_ready !== 1'b0) begin miscompares++; $display("FAIL mr_idle_ready got=%b exp=0", gen_ready); end
      got_q.delete();
      rd_ready = 1'b1;
      start_run(32'd5);
      vectors++; if (gen_start !== 1'b1) begin miscompares++; $display("FAIL mr_relaunch got=%b exp=1", gen_start); end
      tick();
      prod_q = '{32'd42};
      produce(10);
      done_beat(32'd0);
      tick(); tick();
      vectors++; if (count !== 32'd1) begin miscompares++; $display("FAIL mr_rerun_count got=%0d exp=1", count); end
      vectors++; if (sum !== exp_sum) begin miscompares++; $display("FAIL mr_rerun_sum got=%0d exp=%0d", sum, exp_sum); end
      vectors++; if (got_q.size() != 1 || got_q[0] !== 32'd42) begin miscompares++; $display("FAIL mr_rerun_data size=%0d exp size=1 value 42", got_q.size()); end
   endtask

   task automatic test_start_ignored();
      apply_reset();
      rd_ready = 1'b0;
      start_run(32'd2);
      tick();
      prod_q = '{32'd1, 32'd2};
      produce(10);
      done_beat(32'd0);
      tick();
      start_cnt = 0;
      __start = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      __start = 1'b0;
      vectors++; if (start_cnt != 0) begin miscompares++; $display("FAIL si_ignored got=%0d pulses exp=0", start_cnt); end
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL si_retained got=%b exp=1", rd_valid); end
      drain(10);
      vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL si_drained got=%0d exp=2", got_q.size()); end
      start_cnt = 0;
      start_run(32'd6);
      vectors++; if (gen_start !== 1'b1) begin miscompares++; $display("FAIL si_launch got=%b exp=1", gen_start); end
      tick();
      vectors++; if (gen_start !== 1'b0) begin miscompares++; $display("FAIL si_launch_width got=%b exp=0", gen_start); end
      vectors++; if (start_cnt != 1) begin miscompares++; $display("FAIL si_pulse_count got=%0d exp=1", start_cnt); end
      done_beat(32'd0);
      tick();
   endtask

   initial begin
      __reset = 1'b0; __start = 1'b0; n = '0; gen_valid = 1'b0; gen_done = 1'b0;
      gen_output_0 = '0; rd_ready = 1'b0;
      @(posedge __clock);
      #1;
      test_reset();
      test_basic();
      test_immediate();
      test_backpressure();
      test_full_done();
      test_mid_reset();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
